// File: rtl/box_game_pkg.sv
// Shared definitions for the box game: FSM state encodings and legal box codes.
package box_game_pkg;

  localparam int BOX_W = 3;
  localparam logic [BOX_W-1:0] BOX_MIN = 3'd1;
  localparam logic [BOX_W-1:0] BOX_MAX = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_ARMED  = 3'd2,
    ST_RESULT = 3'd3,
    ST_OVER   = 3'd4
  } state_t;

  function automatic logic isValidBox(input logic [BOX_W-1:0] box);
    return (box >= BOX_MIN) && (box <= BOX_MAX);
  endfunction

endpackage

// File: rtl/box_hit_judge_window_timer.sv
// Cycle counter shared by the response window and the feedback hold.
// expired is high during the last of 'limit' running cycles; load restarts the count at 0.
module window_timer #(
  parameter int W = 8
) (
  input  logic         CLOCK_50,
  input  logic         reset_signal,
  input  logic         load,
  input  logic [W-1:0] limit,
  input  logic         run,
  output logic         expired
);

  logic [W-1:0] count_q, count_d;

  assign expired = run && (count_q == limit - W'(1));

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (run && !expired) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset_signal) begin
    if (reset_signal) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/box_hit_judge.sv
// Requests a target box, flashes it, and judges the player's strike as hit, miss or timeout.
// Define SPEEDUP_EN to shrink the response window on every hit (floored at a quarter).
module box_hit_judge
  import box_game_pkg::*;
#(
  parameter int WINDOW_CYCLES   = 50_000_000,
  parameter int FEEDBACK_CYCLES = 12_500_000,
  parameter int START_LIVES     = 3,
  parameter int SCORE_W         = 8
) (
  input  logic               CLOCK_50,
  input  logic               reset_signal,
  input  logic [BOX_W-1:0]   target_box,
  input  logic               target_valid,
  input  logic [BOX_W-1:0]   guess_box,
  input  logic               guess_strobe,
  output logic               req_next,
  output logic               flash_en,
  output logic [BOX_W-1:0]   flash_box,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         lives,
  output logic               game_over
);

  localparam int TIMER_MAX = (WINDOW_CYCLES > FEEDBACK_CYCLES) ? WINDOW_CYCLES : FEEDBACK_CYCLES;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
  localparam logic [TIMER_W-1:0] WINDOW_LIMIT   = TIMER_W'(WINDOW_CYCLES);
  localparam logic [TIMER_W-1:0] FEEDBACK_LIMIT = TIMER_W'(FEEDBACK_CYCLES);

  state_t               state_q, state_d;
  logic [BOX_W-1:0]     targetBox_q, targetBox_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [1:0]           lives_q, lives_d;
  logic                 hitPulse_q, hitPulse_d;
  logic                 missPulse_q, missPulse_d;
  logic [TIMER_W-1:0]   windowLen, timerLimit;
  logic                 timerLoad, timerRun, timerExpired;
  logic                 isJudge, isHit;

  // A guess landing on the timeout cycle wins over the timeout.
  assign isJudge = (state_q == ST_ARMED) && (guess_strobe || timerExpired);
  assign isHit   = (state_q == ST_ARMED) && guess_strobe && (guess_box == targetBox_q);

`ifdef SPEEDUP_EN
  localparam logic [TIMER_W-1:0] WINDOW_STEP  = TIMER_W'(WINDOW_CYCLES / 16);
  localparam logic [TIMER_W-1:0] WINDOW_FLOOR = TIMER_W'(WINDOW_CYCLES / 4);
  logic [TIMER_W-1:0] window_q, window_d;

  always_comb begin
    window_d = window_q;
    if (isHit) begin
      window_d = (window_q < WINDOW_FLOOR + WINDOW_STEP) ? WINDOW_FLOOR : window_q - WINDOW_STEP;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset_signal) begin
    if (reset_signal) begin
      window_q <= WINDOW_LIMIT;
    end else begin
      window_q <= window_d;
    end
  end

  assign windowLen = window_q;
`else
  assign windowLen = WINDOW_LIMIT;
`endif

  assign timerRun   = (state_q == ST_ARMED) || (state_q == ST_RESULT);
  assign timerLimit = (state_q == ST_ARMED) ? windowLen : FEEDBACK_LIMIT;
  assign timerLoad  = (state_d != state_q);

  window_timer #(.W(TIMER_W)) u_timer (
    .CLOCK_50     (CLOCK_50),
    .reset_signal (reset_signal),
    .load         (timerLoad),
    .limit        (timerLimit),
    .run          (timerRun),
    .expired      (timerExpired)
  );

  always_ff @(posedge CLOCK_50 or posedge reset_signal) begin
    if (reset_signal) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = ST_REQ;
      ST_REQ:    if (target_valid && isValidBox(target_box)) state_d = ST_ARMED;
      ST_ARMED:  if (isJudge) state_d = ST_RESULT;
      ST_RESULT: if (timerExpired) state_d = (lives_q == 2'd0) ? ST_OVER : ST_REQ;
      ST_OVER:   state_d = ST_OVER;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_next  = 1'b0;
    flash_en  = 1'b0;
    flash_box = '0;
    game_over = 1'b0;
    case (state_q)
      ST_REQ:   req_next = 1'b1;
      ST_ARMED: begin
        flash_en  = 1'b1;
        flash_box = targetBox_q;
      end
      ST_OVER:  game_over = 1'b1;
      default:  ;
    endcase
  end

  // Score, lives and the judgement pulses all update on the edge that enters RESULT.
  always_comb begin
    targetBox_d = targetBox_q;
    score_d     = score_q;
    lives_d     = lives_q;
    hitPulse_d  = 1'b0;
    missPulse_d = 1'b0;
    if ((state_q == ST_REQ) && target_valid && isValidBox(target_box)) begin
      targetBox_d = target_box;
    end
    if (isHit) begin
      hitPulse_d = 1'b1;
      if (score_q != {SCORE_W{1'b1}}) score_d = score_q + SCORE_W'(1);
    end else if (isJudge) begin
      missPulse_d = 1'b1;
      lives_d     = lives_q - 2'd1;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset_signal) begin
    if (reset_signal) begin
      targetBox_q <= '0;
      score_q     <= '0;
      lives_q     <= 2'(START_LIVES);
      hitPulse_q  <= 1'b0;
      missPulse_q <= 1'b0;
    end else begin
      targetBox_q <= targetBox_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      hitPulse_q  <= hitPulse_d;
      missPulse_q <= missPulse_d;
    end
  end

  assign hit_pulse  = hitPulse_q;
  assign miss_pulse = missPulse_q;
  assign score      = score_q;
  assign lives      = lives_q;

endmodule
